uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_sync2.sv | 14 +
 rtl/uart_receiver.sv | 112 +++++++++++
 tb/tb_uart_receiver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, data width and line idle level
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: 1-bit two-flop synchronizer (clock, reset_n, d -> q) with parameterised reset value
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver (clock, reset_n, rxd -> rx_DATA, rx_done, frame_error); even parity + parity_error when UART_RX_PARITY_EN is defined
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_DATA,
  output logic                 rx_done,
  output logic                 frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic rxs;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif
  uart_sync2 #(.RST_VAL(LINE_IDLE)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (rxd),
    .q      (rxs)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_DATA     <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bit_idx <= '0;
          cnt     <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          cnt <= cnt == MID ? '0 : cnt + 1'b1;
          if (cnt == MID) state <= rxs ? IDLE : DATA;
        end
        DATA: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == LAST_BIT) state <= PARITY;
`else
            if (bit_idx == LAST_BIT) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            par_bit <= rxs;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            if (!rxs) begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if ((^shreg) != par_bit) begin
              parity_error <= 1'b1;
              state        <= IDLE;
`endif
            end else begin
              rx_DATA <= shreg;
              rx_done <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver
module tb_uart_receiver;
  localparam int BIT_NS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam longint P_NS = longint'((NBITS - 10) * BIT_NS);
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic [7:0] rx_DATA;
  logic rx_done;
  logic frame_error;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int viol = 0;
  logic prev_p = 1'b0;
  longint done_t[$];
  logic [7:0] done_d[$];
`ifdef UART_RX_PARITY_EN
  logic parity_error;
  int perr_cnt = 0;
  logic par_flip = 1'b0;
`endif
  uart_receiver #(.CLKS_PER_BIT(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .rx_DATA    (rx_DATA),
    .rx_done    (rx_done),
    .frame_error(frame_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    logic p;
    p = rx_done | frame_error;
    if (rx_done) begin
      done_cnt++;
      done_t.push_back($time);
      done_d.push_back(rx_DATA);
    end
    if (frame_error) ferr_cnt++;
    if (rx_done && frame_error) viol++;
`ifdef UART_RX_PARITY_EN
    if (parity_error) perr_cnt++;
    if (parity_error && p) viol++;
    p = p | parity_error;
`endif
    if (p && prev_p) viol++;
    prev_p = p;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #BIT_NS;
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    #BIT_NS;
`endif
    rxd = stop;
    #BIT_NS;
  endtask
  initial begin
    int b;
    int f;
    longint t0;
    longint lat;
    repeat (3) @(negedge clock);
    check("reset_data", 32'(rx_DATA), 32'h00);
    check("reset_done", 32'(rx_done), 0);
    check("reset_ferr", 32'(frame_error), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    b = done_cnt;
    t0 = $time;
    send_frame(8'hAA, 1'b1);
    #(2 * BIT_NS);
    check("aa_done_count", 32'(done_cnt - b), 1);
    check("aa_data", 32'(rx_DATA), 32'hAA);
    check("aa_no_ferr", 32'(ferr_cnt), 0);
    lat = (done_t.size() > b) ? done_t[b] - t0 : 0;
    check("aa_latency", 32'(lat >= 1530 + P_NS && lat <= 1560 + P_NS), 1);
    b = done_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h0F, 1'b1);
    #(2 * BIT_NS);
    check("b2b_done_count", 32'(done_cnt - b), 2);
    if (done_cnt - b == 2) begin
      check("b2b_first", 32'(done_d[b]), 32'h55);
      check("b2b_second", 32'(done_d[b+1]), 32'h0F);
      check("b2b_spacing", 32'(done_t[b+1] - done_t[b]), 32'(NBITS * BIT_NS));
    end
    b = done_cnt;
    f = ferr_cnt;
    rxd = 1'b0;
    #60;
    rxd = 1'b1;
    #(2 * BIT_NS);
    check("glitch_no_done", 32'(done_cnt - b), 0);
    check("glitch_no_ferr", 32'(ferr_cnt - f), 0);
    send_frame(8'h3C, 1'b1);
    #(2 * BIT_NS);
    check("after_glitch_done", 32'(done_cnt - b), 1);
    check("after_glitch_data", 32'(rx_DATA), 32'h3C);
    b = done_cnt;
    f = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    #1000;
    check("break_ferr", 32'(ferr_cnt - f), 1);
    check("break_no_done", 32'(done_cnt - b), 0);
    check("break_data_held", 32'(rx_DATA), 32'h3C);
    rxd = 1'b1;
    #(3 * BIT_NS);
    check("break_release_done", 32'(done_cnt - b), 0);
    check("break_release_ferr", 32'(ferr_cnt - f), 1);
    b = done_cnt;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
`endif
    fork
      send_frame(8'hC3, 1'b1);
      begin
        #(7 * BIT_NS + 40);
        reset_n = 1'b0;
        #1;
        check("async_reset_data", 32'(rx_DATA), 32'h00);
        #29;
        reset_n = 1'b1;
      end
    join
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    #(3 * BIT_NS);
    check("reset_frame_dropped", 32'(done_cnt - b), 0);
    send_frame(8'h81, 1'b1);
    #(2 * BIT_NS);
    check("post_reset_done", 32'(done_cnt - b), 1);
    check("post_reset_data", 32'(rx_DATA), 32'h81);
`ifdef UART_RX_PARITY_EN
    b = done_cnt;
    f = perr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    #(2 * BIT_NS);
    check("par_bad_perr", 32'(perr_cnt - f), 1);
    check("par_bad_no_done", 32'(done_cnt - b), 0);
    check("par_bad_data_held", 32'(rx_DATA), 32'h81);
    send_frame(8'h07, 1'b1);
    #(2 * BIT_NS);
    check("par_good_done", 32'(done_cnt - b), 1);
    check("par_good_data", 32'(rx_DATA), 32'h07);
    check("par_good_no_perr", 32'(perr_cnt - f), 1);
`endif
    check("pulse_overlap", 32'(viol), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
